// File: rtl/input_conditioner.sv
// input_conditioner: front end between the board switches/push-buttons and the
// bit-serial core. It synchronizes all raw inputs, debounces the three buttons,
// turns each debounced press into a one-cycle pulse, and wraps Execute presses
// in a request/acknowledge handshake toward the control unit.
// Optional feature macro: INPUT_COND_DIN_SNAPSHOT_EN. When it is defined, Din is
// captured on each LoadA/LoadB pulse and held. Otherwise Din follows the switches.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       LoadA_raw,
  input  logic       LoadB_raw,
  input  logic       Execute_raw,
  input  logic [3:0] Din_raw,
  input  logic [2:0] F_raw,
  input  logic [1:0] R_raw,
  input  logic       Exec_ack,
  output logic       LoadA,
  output logic       LoadB,
  output logic [3:0] Din,
  output logic [2:0] F,
  output logic [1:0] R,
  output logic       Exec_req,
  output logic [2:0] Btn_level
);

  // Last count value before the debounced level is allowed to flip.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } execState_t;

  // Button bit order everywhere is {Execute, LoadB, LoadA}.
  logic [2:0] r_btnS1;
  logic [2:0] r_btnS2;
  logic [3:0] r_dinS1;
  logic [3:0] r_dinS2;
  logic [2:0] r_fS1;
  logic [2:0] r_fS2;
  logic [1:0] r_rS1;
  logic [1:0] r_rS2;

  logic [7:0] r_cnt [3];
  logic [2:0] r_deb;
  logic [2:0] r_pulse;

  logic [2:0] r_fHold;
  logic [1:0] r_rHold;

  execState_t r_state;
  logic       r_execReq;

  logic [2:0] w_flip;
  logic [2:0] w_rise;

  // Two-flop synchronizers for every asynchronous board input.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_btnS1 <= '0;
      r_btnS2 <= '0;
      r_dinS1 <= '0;
      r_dinS2 <= '0;
      r_fS1   <= '0;
      r_fS2   <= '0;
      r_rS1   <= '0;
      r_rS2   <= '0;
    end else begin
      r_btnS1 <= {Execute_raw, LoadB_raw, LoadA_raw};
      r_btnS2 <= r_btnS1;
      r_dinS1 <= Din_raw;
      r_dinS2 <= r_dinS1;
      r_fS1   <= F_raw;
      r_fS2   <= r_fS1;
      r_rS1   <= R_raw;
      r_rS2   <= r_rS1;
    end
  end

  // Flip and rising-flip conditions: the debounced level changes this edge.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < 3; i++) begin
      w_flip[i] = (r_btnS2[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST);
    end
    w_rise = w_flip & r_btnS2;
  end

  // Debounce counters and levels; press pulse registered alongside the 0->1 flip.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
      r_deb   <= '0;
      r_pulse <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_btnS2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_deb[i] <= r_btnS2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
      r_pulse <= w_rise;
    end
  end

  // Execute handshake: a press raises the request, an ack clears it; presses while pending are dropped.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_execReq <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise[2]) begin
            r_state   <= PEND;
            r_execReq <= 1'b1;
          end
        end
        PEND: begin
          if (Exec_ack) begin
            r_state   <= IDLE;
            r_execReq <= 1'b0;
          end
        end
      endcase
    end
  end

  // Track F/R while idle so the values seen when the request rises stay frozen while pending.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_fHold <= '0;
      r_rHold <= '0;
    end else if (r_state == IDLE) begin
      r_fHold <= r_fS2;
      r_rHold <= r_rS2;
    end
  end

`ifdef INPUT_COND_DIN_SNAPSHOT_EN
  logic [3:0] r_dinSnap;

  // Capture the data switches on the same edge a LoadA/LoadB pulse is raised.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_dinSnap <= '0;
    end else if (w_rise[0] || w_rise[1]) begin
      r_dinSnap <= r_dinS2;
    end
  end

  assign Din = r_dinSnap;
`else
  assign Din = r_dinS2;
`endif

  assign LoadA     = r_pulse[0];
  assign LoadB     = r_pulse[1];
  assign Exec_req  = r_execReq;
  assign Btn_level = r_deb;
  assign F         = r_execReq ? r_fHold : r_fS2;
  assign R         = r_execReq ? r_rHold : r_rS2;

endmodule

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner: directed scenarios plus randomized stimulus,
// all outputs compared every cycle against a behavioural reference model.
module tb_input_conditioner;

  localparam int DEB = 2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       LoadA_raw, LoadB_raw, Execute_raw, Exec_ack;
  logic [3:0] Din_raw;
  logic [2:0] F_raw;
  logic [1:0] R_raw;
  logic       LoadA, LoadB, Exec_req;
  logic [3:0] Din;
  logic [2:0] F;
  logic [1:0] R;
  logic [2:0] Btn_level;

  int checks = 0;
  int errors = 0;

  // Reference model state: delay lines of sampled inputs, debounced levels,
  // run length of disagreeing samples, pending request and frozen operands.
  logic [2:0] mBtnS1, mBtnS2, mLevel, mPress;
  int         mRun [3];
  logic [3:0] mDinS1, mDinS2, mDinSnap;
  logic [2:0] mFS1, mFS2, mFFrozen;
  logic [1:0] mRS1, mRS2, mRFrozen;
  logic       mReq;

  // Event bookkeeping for directed scenarios.
  int cycleIdx, pulsesA, pulsesB, reqRises, firstA, firstB, firstReq;
  logic prevReq;

  input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
    .Clk(Clk), .Reset(Reset),
    .LoadA_raw(LoadA_raw), .LoadB_raw(LoadB_raw), .Execute_raw(Execute_raw),
    .Din_raw(Din_raw), .F_raw(F_raw), .R_raw(R_raw), .Exec_ack(Exec_ack),
    .LoadA(LoadA), .LoadB(LoadB), .Din(Din), .F(F), .R(R),
    .Exec_req(Exec_req), .Btn_level(Btn_level)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic b, input logic e, input logic [3:0] d,
                               input logic [2:0] f, input logic [1:0] r, input logic ack);
    LoadA_raw   = a;
    LoadB_raw   = b;
    Execute_raw = e;
    Din_raw     = d;
    F_raw       = f;
    R_raw       = r;
    Exec_ack    = ack;
  endtask

  task automatic modelReset();
    mBtnS1 = '0; mBtnS2 = '0; mLevel = '0; mPress = '0;
    for (int i = 0; i < 3; i++) mRun[i] = 0;
    mDinS1 = '0; mDinS2 = '0; mDinSnap = '0;
    mFS1 = '0; mFS2 = '0; mFFrozen = '0;
    mRS1 = '0; mRS2 = '0; mRFrozen = '0;
    mReq = 1'b0;
  endtask

  // One clock edge of the reference: a level flips after DEB consecutive
  // disagreeing samples, a press is a flip to 1.
  task automatic modelEdge();
    mPress = '0;
    for (int i = 0; i < 3; i++) begin
      if (mBtnS2[i] == mLevel[i]) mRun[i] = 0;
      else begin
        mRun[i] = mRun[i] + 1;
        if (mRun[i] == DEB) begin
          mLevel[i] = mBtnS2[i];
          mRun[i]   = 0;
          mPress[i] = mLevel[i];
        end
      end
    end
    if (mPress[0] || mPress[1]) mDinSnap = mDinS2;
    if (!mReq) begin
      if (mPress[2]) begin
        mReq     = 1'b1;
        mFFrozen = mFS2;
        mRFrozen = mRS2;
      end
    end else if (Exec_ack) begin
      mReq = 1'b0;
    end
    mBtnS2 = mBtnS1; mBtnS1 = {Execute_raw, LoadB_raw, LoadA_raw};
    mDinS2 = mDinS1; mDinS1 = Din_raw;
    mFS2   = mFS1;   mFS1   = F_raw;
    mRS2   = mRS1;   mRS1   = R_raw;
  endtask

  task automatic checkAll();
    logic [3:0] expDin;
`ifdef INPUT_COND_DIN_SNAPSHOT_EN
    expDin = mDinSnap;
`else
    expDin = mDinS2;
`endif
    checkOutput("LoadA", 32'(LoadA), 32'(mPress[0]));
    checkOutput("LoadB", 32'(LoadB), 32'(mPress[1]));
    checkOutput("Exec_req", 32'(Exec_req), 32'(mReq));
    checkOutput("Btn_level", 32'(Btn_level), 32'(mLevel));
    checkOutput("F", 32'(F), 32'(mReq ? mFFrozen : mFS2));
    checkOutput("R", 32'(R), 32'(mReq ? mRFrozen : mRS2));
    checkOutput("Din", 32'(Din), 32'(expDin));
  endtask

  task automatic startSeq();
    cycleIdx = 0; pulsesA = 0; pulsesB = 0; reqRises = 0;
    firstA = 0; firstB = 0; firstReq = 0;
  endtask

  task automatic stepCycle();
    @(posedge Clk);
    modelEdge();
    #1;
    checkAll();
    cycleIdx++;
    if (LoadA === 1'b1) begin pulsesA++; if (firstA == 0) firstA = cycleIdx; end
    if (LoadB === 1'b1) begin pulsesB++; if (firstB == 0) firstB = cycleIdx; end
    if (Exec_req === 1'b1 && prevReq !== 1'b1) begin
      reqRises++;
      if (firstReq == 0) firstReq = cycleIdx;
    end
    prevReq = Exec_req;
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) stepCycle();
  endtask

  // Assert reset asynchronously, confirm outputs clear at once, release after a negedge.
  task automatic applyReset();
    Reset = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_LoadA", 32'(LoadA), 32'd0);
    checkOutput("rst_Exec_req", 32'(Exec_req), 32'd0);
    checkOutput("rst_Btn_level", 32'(Btn_level), 32'd0);
    checkAll();
    repeat (2) @(posedge Clk);
    #1;
    checkAll();
    @(negedge Clk);
    Reset   = 1'b1;
    prevReq = 1'b0;
  endtask

  initial begin
    logic a, b, e, ack;
    logic [3:0] d;
    logic [2:0] f;
    logic [1:0] r;

    applyStimulus(0, 0, 0, 4'h0, 3'b000, 2'b00, 0);
    prevReq = 1'b0;
    applyReset();

    // LoadA press held 4 edges with Din = B: one pulse at edge 4.
    startSeq();
    applyStimulus(1, 0, 0, 4'hB, 3'b000, 2'b00, 0);
    runCycles(4);
    applyStimulus(0, 0, 0, 4'hB, 3'b000, 2'b00, 0);
    runCycles(6);
    checkOutput("loadA_count", 32'(pulsesA), 32'd1);
    checkOutput("loadA_edge", 32'(firstA), 32'd4);
    checkOutput("loadA_din", 32'(Din), 32'hB);

    // Single-edge glitch on LoadA: no pulse.
    startSeq();
    applyStimulus(1, 0, 0, 4'hB, 3'b000, 2'b00, 0);
    runCycles(1);
    applyStimulus(0, 0, 0, 4'hB, 3'b000, 2'b00, 0);
    runCycles(8);
    checkOutput("glitch_count", 32'(pulsesA), 32'd0);

    // Bouncing LoadB 1,0,1,1,1,1 then release: one pulse at edge 6, none on release.
    startSeq();
    applyStimulus(0, 1, 0, 4'h0, 3'b000, 2'b00, 0); runCycles(1);
    applyStimulus(0, 0, 0, 4'h0, 3'b000, 2'b00, 0); runCycles(1);
    applyStimulus(0, 1, 0, 4'h0, 3'b000, 2'b00, 0); runCycles(4);
    applyStimulus(0, 0, 0, 4'h0, 3'b000, 2'b00, 0); runCycles(8);
    checkOutput("bounce_count", 32'(pulsesB), 32'd1);
    checkOutput("bounce_edge", 32'(firstB), 32'd6);

    // Execute handshake with frozen F/R.
    startSeq();
    applyStimulus(0, 0, 1, 4'h0, 3'b010, 2'b10, 0);
    runCycles(5);
    applyStimulus(0, 0, 1, 4'h0, 3'b110, 2'b10, 0);
    runCycles(6);
    checkOutput("exec_edge", 32'(firstReq), 32'd4);
    checkOutput("exec_req_held", 32'(Exec_req), 32'd1);
    checkOutput("exec_F_frozen", 32'(F), 32'b010);
    applyStimulus(0, 0, 0, 4'h0, 3'b110, 2'b10, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 4'h0, 3'b110, 2'b10, 0);
    checkOutput("ack_req_clear", 32'(Exec_req), 32'd0);
    checkOutput("ack_F_live", 32'(F), 32'b110);
    checkOutput("ack_R_live", 32'(R), 32'b10);
    runCycles(6);

    // Second Execute press while pending is dropped.
    startSeq();
    applyStimulus(0, 0, 1, 4'h0, 3'b001, 2'b01, 0); runCycles(6);
    applyStimulus(0, 0, 0, 4'h0, 3'b001, 2'b01, 0); runCycles(6);
    applyStimulus(0, 0, 1, 4'h0, 3'b001, 2'b01, 0); runCycles(6);
    applyStimulus(0, 0, 0, 4'h0, 3'b001, 2'b01, 0); runCycles(6);
    checkOutput("drop_rises", 32'(reqRises), 32'd1);
    checkOutput("drop_req_held", 32'(Exec_req), 32'd1);
    applyStimulus(0, 0, 0, 4'h0, 3'b001, 2'b01, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 4'h0, 3'b001, 2'b01, 0);
    checkOutput("drop_req_clear", 32'(Exec_req), 32'd0);
    runCycles(10);
    checkOutput("drop_no_second", 32'(reqRises), 32'd1);

    // Reset mid-count with LoadA held; fresh pulse 4 edges after release.
    applyStimulus(1, 0, 0, 4'h3, 3'b000, 2'b00, 0);
    runCycles(3);
    applyReset();
    startSeq();
    runCycles(10);
    checkOutput("rst_held_count", 32'(pulsesA), 32'd1);
    checkOutput("rst_held_edge", 32'(firstA), 32'd4);
    applyStimulus(0, 0, 0, 4'h3, 3'b000, 2'b00, 0);
    runCycles(6);

    // Randomized stimulus: buttons held for random stretches, switches wander, random ack pulses.
    a = 0; b = 0; e = 0; ack = 0; d = 4'h0; f = 3'b000; r = 2'b00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) a = ~a;
      if ($urandom_range(0, 5) == 0) b = ~b;
      if ($urandom_range(0, 4) == 0) e = ~e;
      if ($urandom_range(0, 7) == 0) d = 4'($urandom);
      if ($urandom_range(0, 7) == 0) f = 3'($urandom);
      if ($urandom_range(0, 7) == 0) r = 2'($urandom);
      ack = (!ack && $urandom_range(0, 5) == 0);
      applyStimulus(a, b, e, d, f, r, ack);
      stepCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
